// File: rtl/filter_ctrl_if.sv
// Configuration and event handshake bundle between filter_ctrl and its host.
interface filter_ctrl_if #(
   parameter int SIZE_ADC_DATA = 14,
   parameter int DW  = SIZE_ADC_DATA + 6,
   parameter int KLW = 8,
   parameter int MW  = 16
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [KLW-1:0]       cfg_k;
   logic [KLW-1:0]       cfg_l;
   logic [MW-1:0]        cfg_m;
   logic signed [DW-1:0] cfg_thr;
   logic                 evt_valid;
   logic                 evt_ready;
   logic signed [DW-1:0] evt_peak;
   logic [31:0]          evt_time;

   modport master (
      output cfg_valid, cfg_k, cfg_l, cfg_m, cfg_thr, evt_ready,
      input  cfg_ready, evt_valid, evt_peak, evt_time
   );

   modport slave (
      input  cfg_valid, cfg_k, cfg_l, cfg_m, cfg_thr, evt_ready,
      output cfg_ready, evt_valid, evt_peak, evt_time
   );
endinterface

// File: rtl/filter_ctrl.sv
// Controls a trapezoid shaping filter: flushes it after start, detects pulses above threshold
// and reports the peak of each pulse. Define FILTER_CTRL_TIMESTAMP_EN to timestamp the peaks.
module filter_ctrl #(
   parameter int SIZE_ADC_DATA = 14,
   parameter int DW  = SIZE_ADC_DATA + 6,
   parameter int KLW = 8,
   parameter int MW  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   filter_ctrl_if.slave         bus,
   input  logic                 start,
   input  logic                 stop,
   output logic                 filt_rst_n,
   output logic [KLW-1:0]       filt_k,
   output logic [KLW-1:0]       filt_l,
   output logic [MW-1:0]        filt_m,
   input  logic signed [DW-1:0] filt_data,
   output logic                 busy,
   output logic                 overflow
);
   localparam int CW = KLW + 2;

   typedef enum logic [1:0] {IDLE, FLUSH, ARMED, PULSE} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        fcnt;
   logic [CW-1:0]        flush_last;
   logic signed [DW-1:0] thr;
   logic signed [DW-1:0] peak;
   logic [31:0]          peak_ts;
   logic                 cfg_xfer, above, peak_cap;
   logic                 evt_done, evt_take, evt_load;

   assign cfg_xfer   = bus.cfg_valid && bus.cfg_ready;
   assign above      = filt_data > thr;
   assign peak_cap   = (state == ARMED && above) || (state == PULSE && filt_data > peak);
   assign evt_done   = state == PULSE && !stop && !above;
   assign evt_take   = bus.evt_valid && bus.evt_ready;
   // A completing pulse may reuse the output slot in the cycle the held event is accepted
   assign evt_load   = evt_done && (!bus.evt_valid || bus.evt_ready);
   // Flush covers 2 cycles of filter reset plus k+l+1 cycles for the filter pipeline to settle
   assign flush_last = CW'(filt_k) + CW'(filt_l) + CW'(2);

   assign bus.cfg_ready = state == IDLE;
   assign busy          = state != IDLE;
   assign filt_rst_n    = !(state == IDLE || (state == FLUSH && fcnt < CW'(2)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state != IDLE && stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && !stop) state_nxt = FLUSH;
            FLUSH:   if (fcnt == flush_last) state_nxt = ARMED;
            ARMED:   if (above) state_nxt = PULSE;
            PULSE:   if (!above) state_nxt = ARMED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                    fcnt <= '0;
      else if (state == FLUSH && state_nxt == FLUSH) fcnt <= fcnt + CW'(1);
      else                                           fcnt <= '0;
   end

   // Zero-length k/l would collapse the trapezoid, so they are stored as 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_k <= KLW'(1);
         filt_l <= KLW'(1);
         filt_m <= '0;
         thr    <= '0;
      end else if (cfg_xfer) begin
         filt_k <= (bus.cfg_k == '0) ? KLW'(1) : bus.cfg_k;
         filt_l <= (bus.cfg_l == '0) ? KLW'(1) : bus.cfg_l;
         filt_m <= bus.cfg_m;
         thr    <= bus.cfg_thr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        peak <= '0;
      else if (peak_cap) peak <= filt_data;
   end

`ifdef FILTER_CTRL_TIMESTAMP_EN
   logic [31:0] ts;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                    ts <= '0;
      else if (state == FLUSH && state_nxt == ARMED) ts <= '0;
      else                                           ts <= ts + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        peak_ts <= '0;
      else if (peak_cap) peak_ts <= ts;
   end
`else
   assign peak_ts = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.evt_valid <= 1'b0;
         bus.evt_peak  <= '0;
         bus.evt_time  <= '0;
         overflow      <= 1'b0;
      end else begin
         if (evt_load) begin
            bus.evt_valid <= 1'b1;
            bus.evt_peak  <= peak;
            bus.evt_time  <= peak_ts;
         end else if (evt_take) begin
            bus.evt_valid <= 1'b0;
         end
         if (cfg_xfer)                  overflow <= 1'b0;
         else if (evt_done && !evt_load) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_filter_ctrl.sv
// Scoreboard bench for filter_ctrl: directed scenarios plus random traffic against a reference model.
module tb_filter_ctrl;
   localparam int DW  = 20;
   localparam int KLW = 8;
   localparam int MW  = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic                 stop = 1'b0;
   logic                 filt_rst_n, busy, overflow;
   logic [KLW-1:0]       filt_k, filt_l;
   logic [MW-1:0]        filt_m;
   logic signed [DW-1:0] filt_data = '0;

   filter_ctrl_if #(.DW(DW), .KLW(KLW), .MW(MW)) bus ();

   filter_ctrl #(.DW(DW), .KLW(KLW), .MW(MW)) dut (
      .clk(clk), .reset(reset), .bus(bus), .start(start), .stop(stop),
      .filt_rst_n(filt_rst_n), .filt_k(filt_k), .filt_l(filt_l), .filt_m(filt_m),
      .filt_data(filt_data), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   typedef struct {int pk; longint tm;} ev_t;
   ev_t sb[$];

   // Reference model: whole-controller view kept as plain flags and counters
   bit          m_run, m_fl, m_pu, m_ev, m_ovf;
   int          m_fpos, m_k, m_l, m_m, m_thr, m_pk;
   int unsigned m_ts, m_pkt;

   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint exp_time(int unsigned t);
`ifdef FILTER_CTRL_TIMESTAMP_EN
      return longint'(t);
`else
      return (t == 0) ? 0 : 0;
`endif
   endfunction

   task automatic model_init();
      m_run = 0; m_fl = 0; m_pu = 0; m_ev = 0; m_ovf = 0;
      m_fpos = 0; m_k = 1; m_l = 1; m_m = 0; m_thr = 0; m_pk = 0;
      m_ts = 0; m_pkt = 0;
   endtask

   task automatic model_edge();
      bit take, done, ts_clr;
      int d;
      d = int'(filt_data);
      take = m_ev && bus.evt_ready;
      done = 0;
      ts_clr = 0;
      if (!m_run) begin
         if (bus.cfg_valid) begin
            m_k = (bus.cfg_k == 0) ? 1 : int'(bus.cfg_k);
            m_l = (bus.cfg_l == 0) ? 1 : int'(bus.cfg_l);
            m_m = int'(bus.cfg_m);
            m_thr = int'(bus.cfg_thr);
            m_ovf = 0;
         end
         if (start && !stop) begin m_run = 1; m_fl = 1; m_fpos = 0; end
      end else if (stop) begin
         m_run = 0; m_fl = 0; m_pu = 0;
      end else if (m_fl) begin
         if (m_fpos == m_k + m_l + 2) begin m_fl = 0; ts_clr = 1; end
         else m_fpos++;
      end else if (!m_pu) begin
         if (d > m_thr) begin m_pu = 1; m_pk = d; m_pkt = m_ts; end
      end else if (d > m_thr) begin
         if (d > m_pk) begin m_pk = d; m_pkt = m_ts; end
      end else begin
         m_pu = 0; done = 1;
      end
      if (done && (!m_ev || take)) begin
         m_ev = 1;
         sb.push_back('{m_pk, exp_time(m_pkt)});
      end else begin
         if (take) m_ev = 0;
         if (done) m_ovf = 1;
      end
      m_ts = ts_clr ? 0 : m_ts + 1;
   endtask

   task automatic check_outputs();
      chk("busy", busy, m_run);
      chk("cfg_ready", bus.cfg_ready, !m_run);
      chk("filt_rst_n", filt_rst_n, m_run && !(m_fl && m_fpos < 2));
      chk("evt_valid", bus.evt_valid, m_ev);
      chk("overflow", overflow, m_ovf);
      chk("filt_k", filt_k, m_k);
      chk("filt_l", filt_l, m_l);
      chk("filt_m", filt_m, m_m);
   endtask

   task automatic step(bit cv, int k, int l, int m, int thr, bit st, bit sp, int d, bit rdy);
      bus.cfg_valid = cv;
      bus.cfg_k = KLW'(k);
      bus.cfg_l = KLW'(l);
      bus.cfg_m = MW'(m);
      bus.cfg_thr = DW'(thr);
      bus.evt_ready = rdy;
      start = st;
      stop = sp;
      filt_data = DW'(d);
      model_edge();
      @(posedge clk);
      #2;
      check_outputs();
   endtask

   task automatic do_reset();
      start = 0; stop = 0; bus.cfg_valid = 0; bus.evt_ready = 0;
      reset = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_filt_rst_n", filt_rst_n, 0);
      chk("rst_evt_valid", bus.evt_valid, 0);
      chk("rst_evt_peak", bus.evt_peak, 0);
      chk("rst_evt_time", bus.evt_time, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_filt_k", filt_k, 1);
      chk("rst_filt_l", filt_l, 1);
      chk("rst_filt_m", filt_m, 0);
      chk("rst_cfg_ready", bus.cfg_ready, 1);
      model_init();
      sb.delete();
      @(posedge clk);
      #2;
      reset = 1;
      check_outputs();
   endtask

   // Monitor: every accepted event must match the oldest expected one
   always @(negedge clk) begin
      ev_t e;
      if (reset && bus.evt_valid && bus.evt_ready) begin
         if (sb.size() == 0) begin
            chk("evt_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("evt_peak", bus.evt_peak, e.pk);
            chk("evt_time", bus.evt_time, e.tm);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lows, busy_lows;
      bus.cfg_valid = 0; bus.cfg_k = '0; bus.cfg_l = '0; bus.cfg_m = '0;
      bus.cfg_thr = '0; bus.evt_ready = 0;
      model_init();
      @(posedge clk);
      #2;
      do_reset();

      // k=l=0 stored as 1, config and start together, then a single pulse
      step(1, 0, 0, 7, 100, 1, 0, 0, 0);
      chk("k0_stored", filt_k, 1);
      chk("l0_stored", filt_l, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 50, 0);
      step(0, 0, 0, 0, 0, 0, 0, 150, 0);
      step(0, 0, 0, 0, 0, 0, 0, 300, 0);
      step(0, 0, 0, 0, 0, 0, 0, 200, 0);
      step(0, 0, 0, 0, 0, 0, 0, 90, 0);
      chk("ev1_valid", bus.evt_valid, 1);
      chk("ev1_peak", bus.evt_peak, 300);
      chk("ev1_time", bus.evt_time, exp_time(3));

      // Second pulse while first is held: dropped, overflow set
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 500, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("ovf_set", overflow, 1);
      chk("held_peak", bus.evt_peak, 300);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("pending_kept", bus.evt_valid, 1);
      step(1, 4, 8, 3, 100, 0, 0, 0, 1);
      chk("ovf_cleared", overflow, 0);

      // k=4, l=8: flush length probed with a falling above-threshold ramp
      lows = 0;
      busy_lows = 0;
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      if (!filt_rst_n) lows++;
      if (!busy) busy_lows++;
      for (int i = 1; i <= 15; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1000 - i, 0);
         if (!filt_rst_n) lows++;
         if (!busy) busy_lows++;
      end
      chk("flush_rst_cycles", lows, 2);
      chk("flush_busy_lows", busy_lows, 0);
      for (int i = 16; i <= 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1000 - i, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("armed_entry_peak", bus.evt_peak, 984);
      chk("armed_entry_time", bus.evt_time, exp_time(0));
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // stop in the middle of a pulse, then start+stop together
      step(0, 0, 0, 0, 0, 0, 0, 250, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("stop_busy", busy, 0);
      chk("stop_filt_rst_n", filt_rst_n, 0);
      chk("stop_no_event", bus.evt_valid, 0);
      step(0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("start_stop_idle", busy, 0);

      // Reset in the middle of a pulse
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 300, 0);
      do_reset();

      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 200)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0,
              int'($urandom_range(0, 400)) - 100, $urandom_range(0, 2) == 0);
      end

      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
